multicycle_main_fsm: RTL and testbench

Main control state machine for the multi-cycle RV32I core. It sits directly upstream of the datapath (PC register, instruction register, shared instruction/data memory, register file, ALU) and sequences each instruction through fetch, decode, execute, memory and writeback cycles. Its per-state control strobes drive the datapath muxes and write enables, including the instruction register write enable. It also keeps a retired-instruction counter and flags illegal opcodes.

---
 rtl/multicycle_main_fsm_if.sv | 35 +++
 rtl/multicycle_main_fsm.sv | 159 +++++++++++++++
 tb/tb_multicycle_main_fsm.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the multi-cycle RV32I main FSM (master) and its datapath (slave).
// Signal names follow the FSM's port naming: i_* into the FSM, o_* out of it.
interface multicycle_main_fsm_if #(
  parameter int RETIRE_CNT_W = 32
);
  logic [6:0]              i_operand;
  logic                    i_zeroFlag;
  logic                    i_memReady;
  logic                    o_pcWrite;
  logic                    o_adrSrc;
  logic                    o_memWriteEn;
  logic                    o_instructionRegWrite;
  logic [1:0]              o_resultSrc;
  logic [1:0]              o_aluSrcA;
  logic [1:0]              o_aluSrcB;
  logic [1:0]              o_aluOp;
  logic                    o_regWriteEn;
  logic [3:0]              o_state;
  logic                    o_illegalInstr;
  logic [RETIRE_CNT_W-1:0] o_retiredCount;

  modport master (
    input  i_operand, i_zeroFlag, i_memReady,
    output o_pcWrite, o_adrSrc, o_memWriteEn, o_instructionRegWrite, o_resultSrc,
           o_aluSrcA, o_aluSrcB, o_aluOp, o_regWriteEn, o_state, o_illegalInstr,
           o_retiredCount
  );

  modport slave (
    output i_operand, i_zeroFlag, i_memReady,
    input  o_pcWrite, o_adrSrc, o_memWriteEn, o_instructionRegWrite, o_resultSrc,
           o_aluSrcA, o_aluSrcB, o_aluOp, o_regWriteEn, o_state, o_illegalInstr,
           o_retiredCount
  );
endinterface

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multi-cycle RV32I core: fetch/decode/execute/memory/writeback sequencing.
// Optional MULTICYCLE_FSM_MEMWAIT_EN: FETCH, MEMREAD and MEMWRITE stall until i_memReady = 1.
module multicycle_main_fsm #(
  parameter int RETIRE_CNT_W = 32
) (
  input logic                   i_clk,
  input logic                   i_arst_n,
  multicycle_main_fsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  state_t                  state;
  state_t                  nextState;
  logic [RETIRE_CNT_W-1:0] retiredCount;
  logic                    illegalFlag;
  logic                    memReady;
  logic                    retire;
  logic                    pcWrite;
  logic                    memWriteEn;
  logic                    instructionRegWrite;
  logic                    regWriteEn;

`ifdef MULTICYCLE_FSM_MEMWAIT_EN
  assign memReady = bus.i_memReady;
`else
  assign memReady = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state        <= FETCH;
      retiredCount <= '0;
      illegalFlag  <= 1'b0;
    end else begin
      state <= nextState;
      if (retire) retiredCount <= retiredCount + RETIRE_CNT_W'(1);
      if (nextState == ILLEGAL) illegalFlag <= 1'b1;
    end
  end

  // NOTE: every signal written here gets a default first, so no branch can infer a latch.
  always_comb begin
    nextState           = FETCH;
    retire              = 1'b0;
    pcWrite             = 1'b0;
    memWriteEn          = 1'b0;
    instructionRegWrite = 1'b0;
    regWriteEn          = 1'b0;
    bus.o_adrSrc        = 1'b0;
    bus.o_resultSrc     = 2'b00;
    bus.o_aluSrcA       = 2'b00;
    bus.o_aluSrcB       = 2'b00;
    bus.o_aluOp         = 2'b00;

    unique case (state)
      FETCH: begin
        // With the stall enabled, PC and IR load only on the ready cycle so PC advances once.
        instructionRegWrite = memReady;
        pcWrite             = memReady;
        bus.o_aluSrcB       = 2'b10;
        bus.o_resultSrc     = 2'b10;
        nextState           = memReady ? DECODE : FETCH;
      end
      DECODE: begin
        bus.o_aluSrcA = 2'b01;
        bus.o_aluSrcB = 2'b01;
        case (bus.i_operand)
          OP_LW, OP_SW: nextState = MEMADR;
          OP_RTYPE:     nextState = EXECUTER;
          OP_ITYPE:     nextState = EXECUTEI;
          OP_JAL:       nextState = JAL;
          OP_BEQ:       nextState = BEQ;
          default:      nextState = ILLEGAL;
        endcase
      end
      MEMADR: begin
        bus.o_aluSrcA = 2'b10;
        bus.o_aluSrcB = 2'b01;
        nextState     = (bus.i_operand == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        bus.o_adrSrc = 1'b1;
        nextState    = memReady ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        bus.o_resultSrc = 2'b01;
        regWriteEn      = 1'b1;
        retire          = 1'b1;
      end
      MEMWRITE: begin
        bus.o_adrSrc = 1'b1;
        memWriteEn   = 1'b1;
        retire       = memReady;
        nextState    = memReady ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        bus.o_aluSrcA = 2'b10;
        bus.o_aluOp   = 2'b10;
        nextState     = ALUWB;
      end
      EXECUTEI: begin
        bus.o_aluSrcA = 2'b10;
        bus.o_aluSrcB = 2'b01;
        bus.o_aluOp   = 2'b10;
        nextState     = ALUWB;
      end
      ALUWB: begin
        regWriteEn = 1'b1;
        retire     = 1'b1;
      end
      JAL: begin
        bus.o_aluSrcA = 2'b01;
        bus.o_aluSrcB = 2'b10;
        pcWrite       = 1'b1;
        nextState     = ALUWB;
      end
      BEQ: begin
        bus.o_aluSrcA = 2'b10;
        bus.o_aluOp   = 2'b01;
        pcWrite       = bus.i_zeroFlag;
        retire        = 1'b1;
      end
      ILLEGAL: nextState = ILLEGAL;
      default: nextState = FETCH;
    endcase
  end

  // Write enables are forced low while reset is asserted, independent of the clock.
  assign bus.o_pcWrite             = pcWrite & i_arst_n;
  assign bus.o_memWriteEn          = memWriteEn & i_arst_n;
  assign bus.o_instructionRegWrite = instructionRegWrite & i_arst_n;
  assign bus.o_regWriteEn          = regWriteEn & i_arst_n;
  assign bus.o_state               = state;
  assign bus.o_illegalInstr        = illegalFlag;
  assign bus.o_retiredCount        = retiredCount;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Randomized bench for multicycle_main_fsm: per-instruction state-path model plus a control table.
// Runs a 32-bit-counter instance and a 4-bit-counter instance side by side for the wrap check.
module tb_multicycle_main_fsm;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
`ifdef MULTICYCLE_FSM_MEMWAIT_EN
  localparam bit MEMWAIT = 1'b1;
`else
  localparam bit MEMWAIT = 1'b0;
`endif

  typedef int intQ_t[$];

  logic       i_clk = 1'b0;
  logic       i_arst_n = 1'b0;
  logic [6:0] operand;
  logic       zeroFlag;
  logic       memReady;
  logic [6:0] legalOps [0:6];

  int          checks = 0;
  int          errors = 0;
  int unsigned retired = 0;

  always #5 i_clk = ~i_clk;

  multicycle_main_fsm_if #(.RETIRE_CNT_W(32)) bus32 ();
  multicycle_main_fsm_if #(.RETIRE_CNT_W(4))  bus4 ();

  multicycle_main_fsm #(.RETIRE_CNT_W(32)) dut (
    .i_clk   (i_clk),
    .i_arst_n(i_arst_n),
    .bus     (bus32.master)
  );

  multicycle_main_fsm #(.RETIRE_CNT_W(4)) dutNarrow (
    .i_clk   (i_clk),
    .i_arst_n(i_arst_n),
    .bus     (bus4.master)
  );

  assign bus32.i_operand  = operand;
  assign bus32.i_zeroFlag = zeroFlag;
  assign bus32.i_memReady = memReady;
  assign bus4.i_operand   = operand;
  assign bus4.i_zeroFlag  = zeroFlag;
  assign bus4.i_memReady  = memReady;

  // {pcWrite, adrSrc, memWriteEn, irWrite, resultSrc, aluSrcA, aluSrcB, aluOp, regWriteEn}
  wire [12:0] ctrl32 = {bus32.o_pcWrite, bus32.o_adrSrc, bus32.o_memWriteEn,
                        bus32.o_instructionRegWrite, bus32.o_resultSrc, bus32.o_aluSrcA,
                        bus32.o_aluSrcB, bus32.o_aluOp, bus32.o_regWriteEn};
  wire [12:0] ctrl4  = {bus4.o_pcWrite, bus4.o_adrSrc, bus4.o_memWriteEn,
                        bus4.o_instructionRegWrite, bus4.o_resultSrc, bus4.o_aluSrcA,
                        bus4.o_aluSrcB, bus4.o_aluOp, bus4.o_regWriteEn};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sequence of states an instruction walks through, from its FETCH onwards.
  function automatic intQ_t pathFor(input logic [6:0] op);
    intQ_t p;
    p.push_back(0);
    p.push_back(1);
    case (op)
      OP_LW:    begin p.push_back(2); p.push_back(3); p.push_back(4); end
      OP_SW:    begin p.push_back(2); p.push_back(5); end
      OP_RTYPE: begin p.push_back(6); p.push_back(7); end
      OP_ITYPE: begin p.push_back(8); p.push_back(7); end
      OP_JAL:   begin p.push_back(9); p.push_back(7); end
      OP_BEQ:   p.push_back(10);
      default:  p.push_back(11);
    endcase
    return p;
  endfunction

  function automatic bit stalls(input int st);
    return MEMWAIT && (st == 0 || st == 3 || st == 5);
  endfunction

  // Control-output table per state, straight from the state output list.
  function automatic logic [12:0] expCtrl(input int st, input bit zero, input bit ready);
    bit pcW = 0, adr = 0, memW = 0, irW = 0, regW = 0;
    logic [1:0] res = 2'b00, srcA = 2'b00, srcB = 2'b00, op = 2'b00;
    case (st)
      0:  begin irW = !MEMWAIT || ready; pcW = irW; srcB = 2'b10; res = 2'b10; end
      1:  begin srcA = 2'b01; srcB = 2'b01; end
      2:  begin srcA = 2'b10; srcB = 2'b01; end
      3:  adr = 1;
      4:  begin res = 2'b01; regW = 1; end
      5:  begin adr = 1; memW = 1; end
      6:  begin srcA = 2'b10; op = 2'b10; end
      7:  regW = 1;
      8:  begin srcA = 2'b10; srcB = 2'b01; op = 2'b10; end
      9:  begin srcA = 2'b01; srcB = 2'b10; pcW = 1; end
      10: begin srcA = 2'b10; op = 2'b01; pcW = zero; end
      default: ;
    endcase
    return {pcW, adr, memW, irW, res, srcA, srcB, op, regW};
  endfunction

  task automatic checkCycle(input int st, input bit zero, input bit ready);
    check("state", bus32.o_state, st);
    check("ctrl", ctrl32, expCtrl(st, zero, ready));
    check("retired", bus32.o_retiredCount, retired);
    check("illegal", bus32.o_illegalInstr, st == 11);
    check("narrowCtrl", ctrl4, expCtrl(st, zero, ready));
    check("narrowRetired", bus4.o_retiredCount, retired % 16);
  endtask

  task automatic checkInReset(input string tag);
    // FETCH selects with every write enable held low.
    check({tag, "State"}, bus32.o_state, 0);
    check({tag, "Ctrl"}, ctrl32, 13'b0_0_0_0_10_00_10_00_0);
    check({tag, "Retired"}, bus32.o_retiredCount, 0);
    check({tag, "Illegal"}, bus32.o_illegalInstr, 0);
    check({tag, "NarrowRetired"}, bus4.o_retiredCount, 0);
  endtask

  // Asserts reset mid-cycle, holds it for some clocks, releases it just after a rising edge.
  task automatic applyReset(input int cycles);
    #2;
    i_arst_n = 1'b0;
    memReady = 1'b0;
    #1;
    checkInReset("rstAsync");
    retired = 0;
    repeat (cycles) begin
      @(negedge i_clk);
      checkInReset("rstHold");
    end
    @(posedge i_clk);
    #1;
    i_arst_n = 1'b1;
  endtask

  task automatic runInstr(input logic [6:0] op, input bit zero);
    intQ_t path;
    path     = pathFor(op);
    operand  = op;
    zeroFlag = zero;
    foreach (path[i]) begin
      int waits;
      waits = 0;
      forever begin
        memReady = (waits >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
        @(negedge i_clk);
        checkCycle(path[i], zero, memReady);
        @(posedge i_clk);
        #1;
        if (!(stalls(path[i]) && !memReady)) break;
        waits++;
      end
    end
    if (path[path.size()-1] != 11) retired++;
  endtask

  task automatic holdIllegal(input int cycles);
    repeat (cycles) begin
      memReady = 1'($urandom_range(0, 1));
      zeroFlag = 1'($urandom_range(0, 1));
      @(negedge i_clk);
      checkCycle(11, zeroFlag, memReady);
      @(posedge i_clk);
      #1;
    end
  endtask

  function automatic bit isLegal(input logic [6:0] op);
    return op == OP_LW || op == OP_SW || op == OP_RTYPE || op == OP_ITYPE ||
           op == OP_JAL || op == OP_BEQ;
  endfunction

  initial begin
    logic [6:0] badOp;
    legalOps[0] = OP_LW;    legalOps[1] = OP_SW;    legalOps[2] = OP_RTYPE;
    legalOps[3] = OP_ITYPE; legalOps[4] = OP_JAL;   legalOps[5] = OP_BEQ;
    legalOps[6] = OP_BEQ;
    operand  = 7'd0;
    zeroFlag = 1'b0;
    memReady = 1'b0;

    applyReset(3);

    // Directed walk through every instruction class, both beq outcomes, then an illegal opcode.
    runInstr(OP_LW, 1'b0);
    runInstr(OP_SW, 1'b0);
    runInstr(OP_RTYPE, 1'b1);
    runInstr(OP_BEQ, 1'b1);
    runInstr(OP_BEQ, 1'b0);
    runInstr(OP_ITYPE, 1'b1);
    runInstr(OP_JAL, 1'b0);
    runInstr(7'b1111111, 1'b0);
    holdIllegal(10);
    applyReset(1);
    runInstr(OP_JAL, 1'b1);

    // Random rounds; each retires well over 16 instructions so the narrow counter wraps.
    for (int round = 0; round < 3; round++) begin
      repeat (40) runInstr(legalOps[$urandom_range(0, 6)], 1'($urandom_range(0, 1)));
      do badOp = 7'($urandom_range(0, 127)); while (isLegal(badOp));
      runInstr(badOp, 1'($urandom_range(0, 1)));
      holdIllegal(3);
      applyReset(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
